// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Purpose:
//   Central stall/flush controller for a 5-stage in-order pipeline. It arbitrates
//   between three stall/flush sources, highest priority first:
//     1. data-memory wait: freeze every stage and bubble MEM/WB
//     2. branch redirect: flush IF/ID and ID/EX
//     3. load-use hazard: hold PC and IF/ID, bubble ID/EX
//   A data-memory access that never completes within MEM_TIMEOUT wait cycles
//   parks the controller in a sticky error state. Only reset leaves it.
//
// Parameters:
//   MEM_TIMEOUT  maximum MEM_WAIT cycles before the error state (1..255)
//   CNT_W        width of the performance counters
//
// Configuration macro:
//   PIPELINE_CTRL_PERF_CNT_EN  when defined, builds saturating stall and flush
//                              counters. Otherwise both counter outputs are tied
//                              to 0.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   lw_stall      in   load-use stall request from the hazard unit
//   br_taken      in   EX-stage branch/jump redirect
//   dmem_req      in   MEM-stage load/store request valid
//   dmem_ack      in   data-memory completion strobe
//   pc_we         out  PC write enable
//   if_id_we      out  IF/ID register write enable
//   id_ex_we      out  ID/EX register write enable
//   ex_mem_we     out  EX/MEM register write enable
//   if_id_flush   out  bubble into IF/ID
//   id_ex_flush   out  bubble into ID/EX
//   mem_wb_flush  out  bubble into MEM/WB
//   mem_err       out  sticky data-memory timeout flag
//   stall_cnt     out  cycles with the PC held (CNT_W bits)
//   flush_cnt     out  cycles with a front-end flush (CNT_W bits)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lw_stall,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;
  logic       advance;

  // State register and wait counter. Reset drops any pending wait or error at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state and output decode.
  // 'advance' marks a cycle in which the pipeline moves forward. Only then do
  // branch and load-use requests have any effect. While frozen, the EX and ID
  // stages hold those requests stable, so they get serviced on the ack cycle.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    advance      = 1'b0;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    mem_err      = 1'b0;

    case (state)
      RUN: begin
        if (dmem_req && !dmem_ack) begin
          mem_wb_flush = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd0;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          advance   = 1'b1;
          state_nxt = RUN;
        end else begin
          mem_wb_flush = 1'b1;
          wait_cnt_nxt = 8'(wait_cnt + 8'd1);
          if ((9'(wait_cnt) + 9'd1) >= TIMEOUT_LIM) begin
            state_nxt = ERR;
          end
        end
      end
      ERR: begin
        mem_err = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    if (advance) begin
      if (br_taken) begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lw_stall) begin
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_we     = 1'b1;
        if_id_we  = 1'b1;
        id_ex_we  = 1'b1;
        ex_mem_we = 1'b1;
      end
    end

    // Outputs are combinational. They must read idle while reset is held,
    // even though the state register already shows RUN.
    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      mem_err      = 1'b0;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating performance counters. pc_we is already forced low during reset,
  // so the reset branch alone keeps reset cycles out of the stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if ((if_id_flush || id_ex_flush) && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Purpose:
//   Self-checking bench for pipeline_ctrl. It uses MEM_TIMEOUT=4 and CNT_W=4,
//   so both the timeout path and counter saturation are reachable in a short run.
//   Each cycle, the expected output vector is pushed to a queue when the inputs
//   are driven. It is popped and compared at the falling edge.
//
//   The expected counter values come from a bench-side tally of the expected
//   pc_we and flush bits, saturated at all-ones. When PIPELINE_CTRL_PERF_CNT_EN
//   is undefined, the counters are expected to read 0.
//
// Output vector bit order:
//   {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
//    mem_wb_flush, mem_err}
//     F0 = RUN idle, FC = branch, 34 = load-use, 02 = memory freeze,
//     01 = error, 00 = reset
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lw_stall = 1'b0;
  logic             br_taken = 1'b0;
  logic             dmem_req = 1'b0;
  logic             dmem_ack = 1'b0;
  logic             pc_we;
  logic             if_id_we;
  logic             id_ex_we;
  logic             ex_mem_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [7:0]       act_outs;

  typedef struct {
    logic       lw;
    logic       br;
    logic       req;
    logic       ack;
    logic [7:0] outs;
  } vec_t;

  typedef struct {
    logic [7:0] outs;
    int         tag;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[17];
  int   checks = 0;
  int   fails = 0;
  int   stall_model = 0;
  int   flush_model = 0;

  pipeline_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lw_stall    (lw_stall),
    .br_taken    (br_taken),
    .dmem_req    (dmem_req),
    .dmem_ack    (dmem_ack),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .id_ex_we    (id_ex_we),
    .ex_mem_we   (ex_mem_we),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .mem_wb_flush(mem_wb_flush),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  assign act_outs = {pc_we, if_id_we, id_ex_we, ex_mem_we,
                     if_id_flush, id_ex_flush, mem_wb_flush, mem_err};

  // Expected counter value for a tally n: saturate at all-ones, or 0 when the
  // counters are compiled out.
  function automatic logic [CNT_W-1:0] expCnt(input int n);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    if (n > (1 << CNT_W) - 1) return {CNT_W{1'b1}};
    return n[CNT_W-1:0];
`else
    if (n < 0) return {CNT_W{1'b1}};
    return '0;
`endif
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(input logic lw, input logic br, input logic req,
                               input logic ack, input logic [7:0] outs, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    lw_stall = lw;
    br_taken = br;
    dmem_req = req;
    dmem_ack = ack;
    e.outs = outs;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  // Pop the oldest expectation and compare the outputs and counters. Then
  // account for this cycle in the counter tally, unless reset is held.
  task automatic checkOutput(input bit in_reset);
    exp_t e;
    logic [CNT_W-1:0] exp_stall;
    logic [CNT_W-1:0] exp_flush;
    checks++;
    if (sbq.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = sbq.pop_front();
    if (act_outs !== e.outs) begin
      fails++;
      $display("[TB] FAIL outs[%0d]: got %b want %b", e.tag, act_outs, e.outs);
    end
    exp_stall = expCnt(stall_model);
    exp_flush = expCnt(flush_model);
    checks++;
    if (stall_cnt !== exp_stall) begin
      fails++;
      $display("[TB] FAIL stall_cnt[%0d]: got %0d want %0d", e.tag, stall_cnt, exp_stall);
    end
    checks++;
    if (flush_cnt !== exp_flush) begin
      fails++;
      $display("[TB] FAIL flush_cnt[%0d]: got %0d want %0d", e.tag, flush_cnt, exp_flush);
    end
    if (!in_reset) begin
      if (!e.outs[7]) stall_model++;
      if (e.outs[3] || e.outs[2]) flush_model++;
    end
  endtask

  task automatic runCycle(input logic lw, input logic br, input logic req,
                          input logic ack, input logic [7:0] outs, input int tag);
    applyStimulus(lw, br, req, ack, outs, tag);
    @(negedge clk);
    checkOutput(1'b0);
  endtask

  // Assert reset in the middle of a cycle, away from both edges, and check that
  // the outputs drop immediately. Hold it for one clock edge, then release it
  // with idle inputs.
  task automatic pulseReset(input int tag);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stall_model = 0;
    flush_model = 0;
    e.outs = 8'h00;
    e.tag  = tag;
    sbq.push_back(e);
    #1;
    checkOutput(1'b1);
    e.tag = tag + 1;
    sbq.push_back(e);
    @(negedge clk);
    checkOutput(1'b1);
    #1;
    lw_stall = 1'b0;
    br_taken = 1'b0;
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    exp_t e0;

    // Cycle-by-cycle sequence from reset. Fields: lw, br, req, ack, expected outs.
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hF0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h34};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hF0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hFC};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFC};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hF0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h34};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h02};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h02};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFC};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hF0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h02};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h34};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'hF0};

    $display("[TB] start: MEM_TIMEOUT=%0d CNT_W=%0d", MEM_TIMEOUT, CNT_W);

    // Reset held with active requests on the inputs: everything must read idle.
    lw_stall = 1'b1;
    br_taken = 1'b1;
    dmem_req = 1'b1;
    e0.outs = 8'h00;
    e0.tag  = 0;
    sbq.push_back(e0);
    @(negedge clk);
    checkOutput(1'b1);
    #1;
    lw_stall = 1'b0;
    br_taken = 1'b0;
    dmem_req = 1'b0;
    dmem_ack = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 17; i++) begin
      runCycle(vecs[i].lw, vecs[i].br, vecs[i].req, vecs[i].ack, vecs[i].outs, 100 + i);
    end

    // Timeout: one RUN freeze cycle plus MEM_TIMEOUT wait cycles, then sticky ERR.
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 200);
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      runCycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 201 + i);
    end
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 210);
    runCycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 211);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 212);

    // Reset clears the error, and the first cycle afterwards is ordinary RUN.
    pulseReset(300);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 302);
    runCycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h34, 303);

    // Reset in the middle of a memory wait abandons the wait.
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 400);
    runCycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 401);
    pulseReset(402);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 404);
    runCycle(1'b0, 1'b1, 1'b0, 1'b0, 8'hFC, 405);
    runCycle(1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 406);

    if (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
